// File: rtl/mlp_infer_sched.sv
// Inference scheduler for the MLP classifier core: buffers one pending input vector,
// launches the core, watches hidden/output completion with a watchdog, and returns tagged results.
module mlp_infer_sched #(
  parameter int IN_DIM      = 64,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TAG_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W*IN_DIM-1:0] in_data,
  output logic [DATA_W*IN_DIM-1:0] core_bus,
  output logic                     core_start,
  input  logic                     core_hidden_done,
  input  logic                     core_finished,
  input  logic [3:0]               core_class_idx,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_class,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic                     busy
);

  localparam int VEC_W = DATA_W * IN_DIM;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_HID, WAIT_OUT} state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [VEC_W-1:0]   active_q, active_d;
  logic [TAG_W-1:0]   tag_cnt_q, tag_cnt_d;
  logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               res_valid_q, res_valid_d;
  logic [3:0]         res_class_q, res_class_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               res_err_q, res_err_d;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    tag_cnt_d    = tag_cnt_q;
    cur_tag_d    = cur_tag_q;
    wdog_d       = wdog_q;
    res_valid_d  = res_valid_q;
    res_class_d  = res_class_q;
    res_tag_d    = res_tag_q;
    res_err_d    = res_err_q;

    if (in_valid && !pend_valid_q) begin
      pend_d       = in_data;
      pend_valid_d = 1'b1;
    end
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // A held result blocks the launch so results never overwrite each other.
        if (pend_valid_q && !res_valid_q) begin
          active_d     = pend_q;
          pend_valid_d = 1'b0;
          cur_tag_d    = tag_cnt_q;
          tag_cnt_d    = tag_cnt_q + 1'b1;
          state_d      = START;
        end
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT_HID;
      end
      WAIT_HID: begin
        wdog_d = wdog_q + 1'b1;
        if (core_hidden_done) begin
          state_d = WAIT_OUT;
        end else if (wdog_q >= WD_LAST) begin
          res_valid_d = 1'b1;
          res_class_d = 4'hF;
          res_err_d   = 1'b1;
          res_tag_d   = cur_tag_q;
          state_d     = IDLE;
        end
      end
      WAIT_OUT: begin
        wdog_d = wdog_q + 1'b1;
        // A finish landing on the timeout cycle still counts as a good result.
        if (core_finished) begin
          res_valid_d = 1'b1;
          res_class_d = core_class_idx;
          res_err_d   = 1'b0;
          res_tag_d   = cur_tag_q;
          state_d     = IDLE;
        end else if (wdog_q >= WD_LAST) begin
          res_valid_d = 1'b1;
          res_class_d = 4'hF;
          res_err_d   = 1'b1;
          res_tag_d   = cur_tag_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= '0;
      tag_cnt_q    <= '0;
      cur_tag_q    <= '0;
      wdog_q       <= '0;
      res_valid_q  <= 1'b0;
      res_class_q  <= '0;
      res_tag_q    <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      tag_cnt_q    <= tag_cnt_d;
      cur_tag_q    <= cur_tag_d;
      wdog_q       <= wdog_d;
      res_valid_q  <= res_valid_d;
      res_class_q  <= res_class_d;
      res_tag_q    <= res_tag_d;
      res_err_q    <= res_err_d;
    end
  end

  assign in_ready   = !pend_valid_q;
  assign core_bus   = active_q;
  assign core_start = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign res_valid  = res_valid_q;
  assign res_class  = res_class_q;
  assign res_tag    = res_tag_q;
  assign res_err    = res_err_q;

endmodule
